// File: rtl/rails_feeder.sv
// rails_feeder: buffers a host frame (header N, then N entries), streams it to the rails checker and reports its verdict.
// Optional macro RAILS_FEEDER_PERM_CHECK_EN rejects frames whose entries are not a permutation of 1..N.
module rails_feeder (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [3:0] in_data,
    output logic       in_ready,
    output logic [3:0] out_data,
    input  logic       rails_valid,
    input  logic       rails_result,
    output logic       done,
    output logic       result,
    output logic       err
);

    localparam logic [3:0] MAX_N = 4'd10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SEND   = 3'd2,
        S_WAIT   = 3'd3,
        S_REPORT = 3'd4
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_n;
    logic [3:0] r_cnt;
    logic [3:0] r_idx;
    logic [3:0] r_buf [0:9];
    logic       r_in_ready;
    logic [3:0] r_out_data;
    logic       r_done;
    logic       r_result;
    logic       r_err;
    logic       w_accept;
    logic       w_last_entry;
    logic       w_frame_bad;
    logic       w_rep_err;
    logic       w_rep_result;
    logic [3:0] w_send_nib;
    logic [3:0] w_rd_idx;

`ifdef RAILS_FEEDER_PERM_CHECK_EN
    logic [15:0] r_seen;
    logic        r_bad;
    logic        w_entry_bad;

    assign w_entry_bad = (in_data == 4'd0) || (in_data > r_n) || r_seen[in_data];
    assign w_frame_bad = r_bad || w_entry_bad;
`else
    assign w_frame_bad = 1'b0;
`endif

    // in_ready is registered from the next state, so it is high exactly in IDLE and LOAD
    assign w_accept     = in_valid && r_in_ready;
    assign w_last_entry = (r_cnt == (r_n - 4'd1));
    assign w_rd_idx     = r_idx - 4'd1;

    // Next-state decode plus the report flags latched on entry to REPORT
    always_comb begin
        w_next       = r_state;
        w_rep_err    = 1'b0;
        w_rep_result = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept && (in_data != 4'd0)) begin
                    if (in_data <= MAX_N) begin
                        w_next = S_LOAD;
                    end else begin
                        w_next    = S_REPORT;
                        w_rep_err = 1'b1;
                    end
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_LOAD: begin
                if (w_accept && w_last_entry) begin
                    if (w_frame_bad) begin
                        w_next    = S_REPORT;
                        w_rep_err = 1'b1;
                    end else begin
                        w_next = S_SEND;
                    end
                end else begin
                    w_next = S_LOAD;
                end
            end
            S_SEND: begin
                if (r_idx == r_n) begin
                    w_next = S_WAIT;
                end else begin
                    w_next = S_SEND;
                end
            end
            S_WAIT: begin
                if (rails_valid) begin
                    w_next       = S_REPORT;
                    w_rep_result = rails_result;
                end else begin
                    w_next = S_WAIT;
                end
            end
            S_REPORT: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Nibble for the serial stream: header first, then the buffered entries
    always_comb begin
        w_send_nib = 4'd0;
        if (r_state == S_SEND) begin
            if (r_idx == 4'd0) begin
                w_send_nib = r_n;
            end else begin
                w_send_nib = r_buf[w_rd_idx];
            end
        end else begin
            w_send_nib = 4'd0;
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Frame length, load counter and send index
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_n   <= 4'd0;
            r_cnt <= 4'd0;
            r_idx <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_n   <= in_data;
                        r_cnt <= 4'd0;
                    end
                end
                S_LOAD: begin
                    r_idx <= 4'd0;
                    if (w_accept) begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_SEND: begin
                    r_idx <= r_idx + 4'd1;
                end
                default: begin
                    r_idx <= r_idx;
                end
            endcase
        end
    end

    // Entry buffer, cleared on each new header and filled in arrival order
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 10; i++) begin
                r_buf[i] <= 4'd0;
            end
        end else if ((r_state == S_IDLE) && w_accept && (in_data != 4'd0)) begin
            for (int i = 0; i < 10; i++) begin
                r_buf[i] <= 4'd0;
            end
        end else if ((r_state == S_LOAD) && w_accept) begin
            r_buf[r_cnt] <= in_data;
        end
    end

`ifdef RAILS_FEEDER_PERM_CHECK_EN
    // Seen-mask and sticky bad flag for the permutation check
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_seen <= 16'd0;
            r_bad  <= 1'b0;
        end else if ((r_state == S_IDLE) && w_accept) begin
            r_seen <= 16'd0;
            r_bad  <= 1'b0;
        end else if ((r_state == S_LOAD) && w_accept) begin
            r_seen[in_data] <= 1'b1;
            r_bad           <= w_frame_bad;
        end
    end
`endif

    // Registered outputs; out_data trails the state by one cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_in_ready <= 1'b1;
            r_out_data <= 4'd0;
            r_done     <= 1'b0;
            r_result   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_in_ready <= (w_next == S_IDLE) || (w_next == S_LOAD);
            r_out_data <= w_send_nib;
            r_done     <= (w_next == S_REPORT);
            r_result   <= w_rep_result;
            r_err      <= w_rep_err;
        end
    end

    assign in_ready = r_in_ready;
    assign out_data = r_out_data;
    assign done     = r_done;
    assign result   = r_result;
    assign err      = r_err;

endmodule

// File: tb/tb_rails_feeder.sv
// Bench for rails_feeder: directed frame table, a mid-frame reset sequence and random frames against a frame-level model.
module tb_rails_feeder;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic [3:0] out_data;
    logic       rails_valid;
    logic       rails_result;
    logic       done;
    logic       result;
    logic       err;

    int n_vec;
    int n_err;

    logic [3:0] f_ent [0:9];

    // kind: 0 = header discarded, 1 = rejected, 2 = sent
    typedef struct packed {
        logic [3:0]  hdr;
        logic [39:0] ents;
        logic [7:0]  dly;
        logic        vd;
        logic [1:0]  kind;
        logic        res;
    } vec_t;

    vec_t tbl [0:9];

    rails_feeder dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .rails_valid  (rails_valid),
        .rails_result (rails_result),
        .done         (done),
        .result       (result),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk4(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [3:0] rn();
        return 4'($urandom_range(0, 15));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [3:0] d, input logic rv, input logic rr);
        in_valid     = v;
        in_data      = d;
        rails_valid  = rv;
        rails_result = rr;
    endtask

    // Frame-level reference: what the feeder should do with header hdr and entries f_ent
    function automatic int model_kind(input logic [3:0] hdr);
        int cnt [0:15];
        if (hdr == 4'd0) return 0;
        if (hdr > 4'd10) return 1;
`ifdef RAILS_FEEDER_PERM_CHECK_EN
        for (int i = 0; i < 16; i++) cnt[i] = 0;
        for (int i = 0; i < int'(hdr); i++) begin
            if (f_ent[i] == 4'd0 || f_ent[i] > hdr || cnt[f_ent[i]] > 0) return 1;
            cnt[f_ent[i]]++;
        end
`else
        cnt[0] = 0;
`endif
        return 2;
    endfunction

    // Drives one frame starting just after a rising edge with the DUT idle, checking every cycle
    task automatic run_frame(input logic [3:0] hdr, input int dly, input logic vd,
                             input int kind, input logic res);
        int         n;
        int         gaps;
        logic       rv;
        logic       rr;
        logic [3:0] exp_o;
        n = (hdr >= 4'd1 && hdr <= 4'd10) ? int'(hdr) : 0;
        drv(1'b1, hdr, rb(), rb());
        @(negedge clk);
        chk1("hdr_ready", in_ready, 1'b1);
        chk4("hdr_out", out_data, 4'd0);
        chk1("hdr_done", done, 1'b0);
        tick();
        if (kind == 0) begin
            drv(1'b0, rn(), rb(), rb());
            @(negedge clk);
            chk1("n0_ready", in_ready, 1'b1);
            chk1("n0_done", done, 1'b0);
            tick();
            return;
        end
        for (int i = 0; i < n; i++) begin
            gaps = $urandom_range(0, 2);
            for (int g = 0; g < gaps; g++) begin
                drv(1'b0, rn(), rb(), rb());
                @(negedge clk);
                chk1("load_ready", in_ready, 1'b1);
                chk4("load_out", out_data, 4'd0);
                tick();
            end
            drv(1'b1, f_ent[i], rb(), rb());
            @(negedge clk);
            chk1("ent_ready", in_ready, 1'b1);
            chk4("ent_out", out_data, 4'd0);
            chk1("ent_done", done, 1'b0);
            tick();
        end
        if (kind == 1) begin
            drv(1'b1, rn(), rb(), rb());
            @(negedge clk);
            chk1("rej_done", done, 1'b1);
            chk1("rej_err", err, 1'b1);
            chk1("rej_result", result, 1'b0);
            chk1("rej_ready", in_ready, 1'b0);
            chk4("rej_out", out_data, 4'd0);
            tick();
        end else begin
            for (int t = 1; t <= n + 2 + dly; t++) begin
                rv = (t <= n + 1) ? rb() : (t == n + 2 + dly);
                rr = (t == n + 2 + dly) ? vd : rb();
                drv(1'b1, rn(), rv, rr);
                if (t == 2) exp_o = hdr;
                else if (t >= 3 && t <= n + 2) exp_o = f_ent[t - 3];
                else exp_o = 4'd0;
                @(negedge clk);
                chk4("stream_out", out_data, exp_o);
                chk1("stream_done", done, 1'b0);
                chk1("stream_ready", in_ready, 1'b0);
                tick();
            end
            drv(1'b1, rn(), rb(), rb());
            @(negedge clk);
            chk1("rep_done", done, 1'b1);
            chk1("rep_result", result, res);
            chk1("rep_err", err, 1'b0);
            chk1("rep_ready", in_ready, 1'b0);
            chk4("rep_out", out_data, 4'd0);
            tick();
        end
        drv(1'b0, rn(), rb(), rb());
        @(negedge clk);
        chk1("post_done", done, 1'b0);
        chk1("post_ready", in_ready, 1'b1);
        chk4("post_out", out_data, 4'd0);
        tick();
    endtask

    initial begin
        int         kind;
        int         n;
        int         j;
        logic [3:0] hdr;
        logic [3:0] tmp;
        logic       vd;
        n_vec = 0;
        n_err = 0;

        tbl[0] = '{4'd5,  40'h0000054321, 8'd3, 1'b1, 2'd2, 1'b1};
        tbl[1] = '{4'd5,  40'h0000032145, 8'd1, 1'b0, 2'd2, 1'b0};
`ifdef RAILS_FEEDER_PERM_CHECK_EN
        tbl[2] = '{4'd3,  40'h0000000211, 8'd0, 1'b1, 2'd1, 1'b0};
        tbl[8] = '{4'd4,  40'h0000003201, 8'd0, 1'b1, 2'd1, 1'b0};
        tbl[9] = '{4'd3,  40'h0000000421, 8'd0, 1'b1, 2'd1, 1'b0};
`else
        tbl[2] = '{4'd3,  40'h0000000211, 8'd0, 1'b1, 2'd2, 1'b1};
        tbl[8] = '{4'd4,  40'h0000003201, 8'd2, 1'b0, 2'd2, 1'b0};
        tbl[9] = '{4'd3,  40'h0000000421, 8'd0, 1'b1, 2'd2, 1'b1};
`endif
        tbl[3] = '{4'd12, 40'h0000000000, 8'd0, 1'b0, 2'd1, 1'b0};
        tbl[4] = '{4'd0,  40'h0000000000, 8'd0, 1'b0, 2'd0, 1'b0};
        tbl[5] = '{4'd10, 40'h123456789A, 8'd5, 1'b1, 2'd2, 1'b1};
        tbl[6] = '{4'd1,  40'h0000000001, 8'd0, 1'b0, 2'd2, 1'b0};
        tbl[7] = '{4'd11, 40'h0000000000, 8'd0, 1'b1, 2'd1, 1'b0};

        reset = 1'b1;
        drv(1'b0, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk1("rst_ready", in_ready, 1'b1);
        chk4("rst_out", out_data, 4'd0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_result", result, 1'b0);
        chk1("rst_err", err, 1'b0);
        tick();
        reset = 1'b0;
        tick();

        for (int v = 0; v < 10; v++) begin
            for (int i = 0; i < 10; i++) f_ent[i] = tbl[v].ents[4 * i +: 4];
            run_frame(tbl[v].hdr, int'(tbl[v].dly), tbl[v].vd, int'(tbl[v].kind), tbl[v].res);
        end

        // Reset in the middle of sending 4,4,3,2,1
        f_ent[0] = 4'd4; f_ent[1] = 4'd3; f_ent[2] = 4'd2; f_ent[3] = 4'd1;
        drv(1'b1, 4'd4, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drv(1'b1, f_ent[i], 1'b0, 1'b0);
            tick();
        end
        drv(1'b0, 4'd0, 1'b0, 1'b0);
        tick();
        @(negedge clk);
        chk4("mid_send_out", out_data, 4'd4);
        #2;
        reset = 1'b1;
        #1;
        chk4("mid_rst_out", out_data, 4'd0);
        chk1("mid_rst_ready", in_ready, 1'b1);
        chk1("mid_rst_done", done, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk1("mid_rst_done2", done, 1'b0);
        chk4("mid_rst_out2", out_data, 4'd0);
        tick();
        reset = 1'b0;
        f_ent[0] = 4'd1;
        run_frame(4'd1, 2, 1'b1, 2, 1'b1);

        for (int r = 0; r < 40; r++) begin
            hdr = rn();
            n = (hdr >= 4'd1 && hdr <= 4'd10) ? int'(hdr) : 0;
            for (int i = 0; i < 10; i++) f_ent[i] = 4'd0;
            if (rb()) begin
                for (int i = 0; i < n; i++) f_ent[i] = 4'(i + 1);
                for (int i = n - 1; i > 0; i--) begin
                    j = $urandom_range(0, i);
                    tmp = f_ent[i]; f_ent[i] = f_ent[j]; f_ent[j] = tmp;
                end
            end else begin
                for (int i = 0; i < n; i++) f_ent[i] = rn();
            end
            kind = model_kind(hdr);
            vd = rb();
            run_frame(hdr, $urandom_range(0, 4), vd, kind, (kind == 2) ? vd : 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rails_feeder.md
RAILS_FEEDER -- requirements
Module: rails_feeder

Interface
REQ-001 SHALL have clk  input  1  rising-edge clock for all sequential logic.
REQ-002 SHALL have reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have in_valid  input  1  host nibble present on in_data.
REQ-004 SHALL have in_data  input  4  host frame nibble: header N first, then N departure entries.
REQ-005 SHALL have in_ready  output  1  feeder accepts a nibble this cycle.
REQ-006 SHALL have out_data  output  4  serialized stream to the rails checker.
REQ-007 SHALL have rails_valid  input  1  one-cycle verdict strobe from the rails checker.
REQ-008 SHALL have rails_result  input  1  verdict bit, sampled only when rails_valid=1.
REQ-009 SHALL have done  output  1  one-cycle frame-complete pulse.
REQ-010 SHALL have result  output  1  frame verdict, qualified by done.
REQ-011 SHALL have err  output  1  frame rejected without being sent, qualified by done.

Function
REQ-012 SHALL accept a nibble only on a cycle where in_valid=1 and in_ready=1.
REQ-013 SHALL implement the states IDLE, LOAD, SEND, WAIT and REPORT.
REQ-014 SHALL in IDLE drive in_ready=1 and treat the first accepted nibble as header N.
REQ-015 SHALL discard a header N=0 silently, remaining in IDLE with no done pulse.
REQ-016 SHALL on a header N in 1..10 store N, clear the 10-entry buffer and the seen-mask, and go to LOAD.
REQ-017 SHALL on a header N in 11..15 skip LOAD and SEND and go to REPORT with err=1.
REQ-018 SHALL in LOAD keep in_ready=1, write accepted entries to the buffer in arrival order, and count them with a 4-bit counter.
REQ-019 SHALL leave LOAD after the Nth accepted entry: to SEND if the frame is clean, else to REPORT with err=1.
REQ-020 SHALL in SEND, WAIT and REPORT drive in_ready=0.
REQ-021 SHALL in SEND drive out_data=N on the first cycle, then entries 1..N on the next N consecutive cycles, with no bubbles, then go to WAIT.
REQ-022 SHALL drive out_data=0 in every state other than SEND.
REQ-023 SHALL in WAIT hold until rails_valid=1, capture rails_result on that cycle, then go to REPORT.
REQ-024 SHALL in REPORT assert done=1 for exactly one cycle, with result equal to the captured verdict and err=0 for a sent frame.
REQ-025 SHALL for a rejected frame assert done=1 with result=0 and err=1.
REQ-026 SHALL return from REPORT to IDLE on the next cycle.
REQ-027 SHALL ignore rails_valid outside WAIT.
REQ-028 SHALL ignore in_valid whenever in_ready=0, with no data lost from the buffer.
REQ-029 SHALL give a first out_data of N exactly 2 cycles after acceptance of the last entry.

Reset
REQ-030 SHALL on reset immediately enter IDLE.
REQ-031 SHALL on reset clear the buffer count, the seen-mask, N and the captured verdict.
REQ-032 SHALL drive the outputs to in_ready=1, out_data=0, done=0, result=0 and err=0 while reset is high.
REQ-033 SHALL on reset in mid-frame (LOAD, SEND or WAIT) abandon the frame with no done pulse.
REQ-034 SHALL after reset deassertion start a fresh frame with the next accepted nibble.

Configuration
REQ-035 SHALL under RAILS_FEEDER_PERM_CHECK_EN mark a frame as not clean if any entry is 0, any entry exceeds N, or any entry repeats within the frame (checked by seen-mask); the frame is rejected per REQ-025.
REQ-036 SHALL without RAILS_FEEDER_PERM_CHECK_EN treat every frame with N in 1..10 as clean, omit the seen-mask logic, and still apply REQ-017.

Verification
REQ-037 SHALL pass: frame 5,1,2,3,4,5 with rails_valid/rails_result=1 issued 3 cycles after the stream -> out_data sequence 5,1,2,3,4,5, then done=1, result=1, err=0.
REQ-038 SHALL pass: frame 5,5,4,1,2,3 with the stub returning 0 -> stream sent in full, then done=1, result=0, err=0.
REQ-039 SHALL pass: with RAILS_FEEDER_PERM_CHECK_EN defined, frame 3,1,1,2 -> no SEND (out_data stays 0), done=1, err=1; without the macro the stream 3,1,1,2 is sent.
REQ-040 SHALL pass: header 12 -> done=1, err=1 one state later, in_ready back to 1; header 0 -> no done, in_ready held at 1.
REQ-041 SHALL pass: reset asserted during SEND of frame 4,4,3,2,1 -> out_data=0 at once, no done; the next frame 1,1 completes normally.
REQ-042 SHALL pass: rails_valid pulsed during LOAD, then in_valid held high during WAIT -> both ignored, the buffer is unchanged, and the verdict comes only from the pulse in WAIT.
